mem_arb_6502: RTL and testbench

MEM_ARB_6502 -- requirements
Module: mem_arb_6502

---
 rtl/mem_arb_6502_pkg.sv | 13 +
 rtl/mem_arb_6502.sv | 182 ++++++++++++++++++
 tb/tb_mem_arb_6502.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_6502_pkg.sv
// Shared definitions for the 6502 memory arbiter.
// Burst length matches the cache_6502 line fill.
package mem_arb_6502_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_BURST
  } arb_state_t;

  localparam int ARB_BURST_LEN = 8;

endpackage

// File: rtl/mem_arb_6502.sv
// Two-requester memory arbiter (cpu cache, dma/debug).
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority.
module mem_arb_6502
  import mem_arb_6502_pkg::*;
#(
  parameter int BURST_LEN = ARB_BURST_LEN
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [23:0] r0_addr,
  input  logic        r0_en,
  input  logic        r0_wr,
  input  logic        r0_rburst,
  input  logic [7:0]  r0_wdata,
  output logic        r0_rdy,
  output logic        r0_rdata_load,

  input  logic [23:0] r1_addr,
  input  logic        r1_en,
  input  logic        r1_wr,
  input  logic        r1_rburst,
  input  logic [7:0]  r1_wdata,
  output logic        r1_rdy,
  output logic        r1_rdata_load,

  output logic [7:0]  rdata,
  output logic [7:0]  rdata0,

  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_rburst,
  output logic        mem_wburst,
  output logic [7:0]  mem_wdata,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  mem_rdata0,
  input  logic        mem_rdata_load
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  arb_state_t    state, state_n;
  logic          owner, owner_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          win;
  logic          any_req;
  logic          idle;
  logic          sel;
  logic          active;
  logic          burst_req;

  logic [23:0]   s_addr;
  logic          s_en;
  logic          s_wr;
  logic          s_rburst;
  logic [7:0]    s_wdata;

`ifdef MEM_ARB_RR_EN
  logic          last_served;
  logic          done;
`endif

  assign any_req = r0_en | r1_en;
  assign idle    = (state == ST_IDLE);

  // Winner of a new request while idle.
  always_comb begin
    win = r1_en & ~r0_en;
`ifdef MEM_ARB_RR_EN
    if (r0_en && r1_en)
      win = ~last_served;
`endif
  end

  assign sel    = idle ? win : owner;
  assign active = ~idle | any_req;

  // Owner mux: idle follows the winner, busy follows the owner.
  always_comb begin
    s_addr   = r0_addr;
    s_en     = r0_en;
    s_wr     = r0_wr;
    s_rburst = r0_rburst;
    s_wdata  = r0_wdata;
    if (sel) begin
      s_addr   = r1_addr;
      s_en     = r1_en;
      s_wr     = r1_wr;
      s_rburst = r1_rburst;
      s_wdata  = r1_wdata;
    end
  end

  assign burst_req = s_en & s_rburst & ~s_wr;

  assign mem_addr   = s_addr;
  assign mem_wdata  = s_wdata;
  assign mem_en     = s_en;
  assign mem_wr     = idle ? (s_en & s_wr) : s_wr;
  assign mem_rburst = idle ? (s_en & s_rburst) : s_rburst;
  assign mem_wburst = 1'b0;

  assign r0_rdy        = mem_rdy & active & ~sel;
  assign r1_rdy        = mem_rdy & active & sel;
  assign r0_rdata_load = mem_rdata_load & active & ~sel;
  assign r1_rdata_load = mem_rdata_load & active & sel;

  assign rdata  = mem_rdata;
  assign rdata0 = mem_rdata0;

  // Next-state, owner and beat counter.
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          owner_n = win;
          cnt_n   = '0;
          if (burst_req) begin
            state_n = ST_BURST;
            if (mem_rdata_load)
              cnt_n = CW'(1);
          end else if (!mem_rdata_load) begin
            state_n = ST_SINGLE;
          end
        end
      end
      ST_SINGLE: begin
        if (mem_rdata_load)
          state_n = ST_IDLE;
      end
      ST_BURST: begin
        if (mem_rdata_load) begin
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

`ifdef MEM_ARB_RR_EN
  assign done = mem_rdata_load & (
                  (idle & any_req & ~burst_req) |
                  (state == ST_SINGLE) |
                  ((state == ST_BURST) & (cnt == LAST)));

  // Remember who finished last so the other side wins a tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_served <= 1'b1;
    else if (done)
      last_served <= owner_n;
  end
`endif

endmodule

// File: tb/tb_mem_arb_6502.sv
// Scoreboard bench for mem_arb_6502.
// Expected load owners/addresses are queued as beats are driven.
module tb_mem_arb_6502;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] r0_addr = '0, r1_addr = '0;
  logic        r0_en = 0, r0_wr = 0, r0_rburst = 0;
  logic        r1_en = 0, r1_wr = 0, r1_rburst = 0;
  logic [7:0]  r0_wdata = '0, r1_wdata = '0;
  logic        r0_rdy, r0_rdata_load, r1_rdy, r1_rdata_load;
  logic [7:0]  rdata, rdata0;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr, mem_rburst, mem_wburst;
  logic [7:0]  mem_wdata;
  logic        mem_rdy = 1'b1;
  logic [7:0]  mem_rdata = '0, mem_rdata0 = '0;
  logic        mem_rdata_load = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] addr;
    logic        who;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_arb_6502 #(.BURST_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .r0_addr(r0_addr), .r0_en(r0_en), .r0_wr(r0_wr),
    .r0_rburst(r0_rburst), .r0_wdata(r0_wdata),
    .r0_rdy(r0_rdy), .r0_rdata_load(r0_rdata_load),
    .r1_addr(r1_addr), .r1_en(r1_en), .r1_wr(r1_wr),
    .r1_rburst(r1_rburst), .r1_wdata(r1_wdata),
    .r1_rdy(r1_rdy), .r1_rdata_load(r1_rdata_load),
    .rdata(rdata), .rdata0(rdata0),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rburst(mem_rburst), .mem_wburst(mem_wburst),
    .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
    .mem_rdata_load(mem_rdata_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [23:0] a, input logic w);
    exp_t e;
    e.addr = a;
    e.who  = w;
    exp_q.push_back(e);
    mem_rdata_load = 1'b1;
    mem_rdata  = 8'($urandom);
    mem_rdata0 = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
    mem_rdata_load = 1'b0;
  endtask

  // Every forwarded load is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && mem_rdata_load) begin
      if (exp_q.size() == 0) begin
        chk("spur_l0", 32'(r0_rdata_load), 32'd0);
        chk("spur_l1", 32'(r1_rdata_load), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ld_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("ld_l0", 32'(r0_rdata_load), 32'(!mon_e.who));
        chk("ld_l1", 32'(r1_rdata_load), 32'(mon_e.who));
        chk("rdata", 32'(rdata), 32'(mem_rdata));
        chk("rdata0", 32'(rdata0), 32'(mem_rdata0));
      end
    end
  end

  initial begin
    logic w;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_wburst", 32'(mem_wburst), 32'd0);
    chk("rst_rdy0", 32'(r0_rdy), 32'd0);
    nx();

    // simultaneous singles, r0 first
    r0_addr = 24'h001234; r0_en = 1;
    r1_addr = 24'h005678; r1_en = 1;
    @(negedge clk);
    chk("g27_addr", 32'(mem_addr), 32'h001234);
    chk("g27_rdy0", 32'(r0_rdy), 32'd1);
    chk("g27_rdy1", 32'(r1_rdy), 32'd0);
    nx();
    ld(24'h001234, 1'b0);
    nx();
    r0_en = 0;
    @(negedge clk);
    chk("g27_addr1", 32'(mem_addr), 32'h005678);
    chk("g27_rdy1b", 32'(r1_rdy), 32'd1);
    nx();
    ld(24'h005678, 1'b1);
    nx();
    r1_en = 0;

    // burst blocks a write from r1
    r0_addr = 24'h00F000; r0_en = 1; r0_rburst = 1;
    @(negedge clk);
    chk("g28_rburst", 32'(mem_rburst), 32'd1);
    nx();
    for (int b = 0; b < 8; b++) begin
      ld(24'h00F000, 1'b0);
      if (b >= 2) chk("g28_blk", 32'(r1_rdy), 32'd0);
      nx();
      if (b == 1) begin
        r1_addr = 24'h000010; r1_wr = 1;
        r1_wdata = 8'hA5; r1_en = 1;
      end
      if (b == 7) r0_en = 0;
    end
    @(negedge clk);
    chk("g28_wr", 32'(mem_wr), 32'd1);
    chk("g28_waddr", 32'(mem_addr), 32'h000010);
    chk("g28_wdata", 32'(mem_wdata), 32'hA5);
    nx();
    ld(24'h000010, 1'b1);
    nx();
    r1_en = 0; r1_wr = 0;
    @(negedge clk);
    chk("g28_idle", 32'(mem_en), 32'd0);
    nx();

    // burst with first beat on grant, owner drops en early
    r0_addr = 24'h00F100; r0_en = 1; r0_rburst = 1;
    ld(24'h00F100, 1'b0);
    nx();
    for (int b = 1; b < 7; b++) begin
      ld(24'h00F100, 1'b0);
      nx();
    end
    r0_en = 0;
    ld(24'h00F100, 1'b0);
    chk("g29_en", 32'(mem_en), 32'd0);
    nx();
    r0_rburst = 0;
    r1_addr = 24'h002000; r1_en = 1;
    @(negedge clk);
    chk("g29_idle_addr", 32'(mem_addr), 32'h002000);
    chk("g29_rdy1", 32'(r1_rdy), 32'd1);
    nx();
    ld(24'h002000, 1'b1);
    nx();
    r1_en = 0;

    // spurious load while idle
    mem_rdata_load = 1;
    @(negedge clk);
    chk("g32_en", 32'(mem_en), 32'd0);
    nx();
    r0_addr = 24'h003000; r0_en = 1;
    ld(24'h003000, 1'b0);
    nx();
    r0_en = 0;

    // reset on beat 4 of a burst
    r0_addr = 24'h004000; r0_en = 1; r0_rburst = 1;
    @(negedge clk);
    nx();
    for (int b = 0; b < 3; b++) begin
      ld(24'h004000, 1'b0);
      nx();
    end
    mem_rdata_load = 1; rst = 1;
    @(negedge clk);
    nx();
    rst = 0; r0_en = 0; r0_rburst = 0;
    mem_rdata_load = 1;
    @(negedge clk);
    chk("g31_en", 32'(mem_en), 32'd0);
    chk("g31_l0", 32'(r0_rdata_load), 32'd0);
    nx();
    r1_addr = 24'h005000; r1_en = 1;
    @(negedge clk);
    chk("g31_addr", 32'(mem_addr), 32'h005000);
    chk("g31_rdy1", 32'(r1_rdy), 32'd1);
    nx();
    ld(24'h005000, 1'b1);
    nx();
    r1_en = 0;

    // continuous contention
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    r0_addr = 24'h006000; r0_en = 1;
    r1_addr = 24'h007000; r1_en = 1;
    for (int t = 0; t < 8; t++) begin
`ifdef MEM_ARB_RR_EN
      w = t[0];
`else
      w = 1'b0;
`endif
      ld(w ? 24'h007000 : 24'h006000, w);
      chk("g30_rdy1", 32'(r1_rdy), 32'(w));
      nx();
    end
    r0_en = 0; r1_en = 0;
    @(negedge clk);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
